// File: rtl/fan_ctrl_pkg.sv
// Shared encodings for the fan ramp controller: state codes and the
// bit layout of the host control word and the status word.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RAMP = 2'd2,
    ST_HOLD = 2'd3
  } fan_state_e;

  localparam int unsigned CTL_DUTY_LSB  = 0;
  localparam int unsigned CTL_DUTY_W    = 8;
  localparam int unsigned CTL_EN_BIT    = 8;
  localparam int unsigned CTL_RATE_LSB  = 12;
  localparam int unsigned CTL_RATE_W    = 4;
  localparam int unsigned CTL_FORCE_BIT = 16;

  localparam int unsigned STS_CUR_LSB   = 0;
  localparam int unsigned STS_STATE_LSB = 8;
  localparam int unsigned STS_BUSY_BIT  = 10;

  function automatic logic [31:0] pack_status(fan_state_e s, logic [7:0] cur);
    logic [31:0] w;
    w = '0;
    w[STS_CUR_LSB +: 8]   = cur;
    w[STS_STATE_LSB +: 2] = s;
    w[STS_BUSY_BIT]       = (s == ST_KICK) || (s == ST_RAMP);
    return w;
  endfunction

endpackage

// File: rtl/fan_ramp_ctrl_if.sv
// Link between the PWM timebase/comparator and the controller FSM.
interface fan_ramp_ctrl_if;
  logic [7:0] duty;
  logic [7:0] tick_cnt;
  logic       period_end;
  logic       pwm_raw;

  modport master (input duty, output tick_cnt, output period_end, output pwm_raw);
  modport slave  (output duty, input tick_cnt, input period_end, input pwm_raw);
endinterface

// File: rtl/fan_ramp_ctrl_pwm_gen.sv
// PWM timebase: prescaler, 8-bit tick counter wrapping every 256 ticks,
// and the duty comparator.
module fan_pwm_gen #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fan_ramp_ctrl_if.master  pwm
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;
  logic [7:0]    tick_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
      tick_cnt <= tick_cnt + 8'd1;
    end else begin
      pre_cnt  <= pre_cnt + PW'(1);
    end
  end

  assign pwm.tick_cnt   = tick_cnt;
  assign pwm.period_end = tick && (tick_cnt == '1);
  assign pwm.pwm_raw    = (tick_cnt < pwm.duty);

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed controller: kick-start from OFF, rate-limited ramp to the
// requested duty, all changes applied on PWM period boundaries.
module fan_ramp_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE     = 8,
  parameter int unsigned KICK_PERIODS = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] fan_control,
  output logic        fan_pwm,
  output logic [31:0] fan_status
);

  localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

  fan_state_e      state;
  logic [7:0]      cur;
  logic [KW-1:0]   kick_cnt;
  logic [3:0]      rate_cnt;

  logic [7:0]      tgt;
  logic [3:0]      rate;
  logic            force_full;
  logic [7:0]      cur_step;

  fan_ramp_ctrl_if pwm_bus ();

  fan_pwm_gen #(.PRESCALE(PRESCALE)) u_pwm_gen (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .pwm   (pwm_bus.master)
  );

  assign pwm_bus.duty = cur;

  assign tgt        = fan_control[CTL_EN_BIT] ? fan_control[CTL_DUTY_LSB +: CTL_DUTY_W] : '0;
  assign rate       = fan_control[CTL_RATE_LSB +: CTL_RATE_W];
  assign force_full = fan_control[CTL_FORCE_BIT];
  assign cur_step   = (tgt > cur) ? cur + 8'd1 : cur - 8'd1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= ST_OFF;
      cur        <= '0;
      kick_cnt   <= '0;
      rate_cnt   <= '0;
      fan_pwm    <= 1'b0;
      fan_status <= '0;
    end else begin
      fan_pwm    <= force_full | (state == ST_KICK) | pwm_bus.pwm_raw;
      fan_status <= pack_status(state, cur);
      if (pwm_bus.period_end) begin
        unique case (state)
          ST_OFF: begin
            cur <= '0;
            if (tgt != '0) begin
              state    <= ST_KICK;
              kick_cnt <= KW'(KICK_PERIODS - 1);
            end
          end
          ST_KICK: begin
            rate_cnt <= '0;
            // A target dropped during the kick lands in RAMP at zero so the
            // next evaluation settles to OFF through the normal path.
            if (tgt == '0) begin
              state <= ST_RAMP;
              cur   <= '0;
            end else if (kick_cnt == '0) begin
              state <= ST_RAMP;
              cur   <= '1;
            end else begin
              kick_cnt <= kick_cnt - KW'(1);
            end
          end
          ST_RAMP: begin
            if (cur == tgt) begin
              state <= (tgt != '0) ? ST_HOLD : ST_OFF;
            end else if (rate_cnt >= rate) begin
              cur      <= cur_step;
              rate_cnt <= '0;
              if (cur_step == tgt) state <= (tgt != '0) ? ST_HOLD : ST_OFF;
            end else begin
              rate_cnt <= rate_cnt + 4'd1;
            end
          end
          ST_HOLD: begin
            if (tgt != cur) begin
              state    <= ST_RAMP;
              rate_cnt <= '0;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule
